// File: rtl/c0880_pkg.sv
// c0880_pkg
// Shared definitions for the c0880 vector sequencer slice.
//   VEC_W         ALU input width  (G1..G60)
//   RES_W         ALU output width (G855..G880)
//   BYTES_PER_VEC bytes streamed in per vector
//   state_e       sequencer states
//   sig_step      one rotate-left-by-one then XOR step of the result signature
package c0880_pkg;

  localparam int VEC_W         = 60;
  localparam int RES_W         = 26;
  localparam int BYTES_PER_VEC = 8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } state_e;

  function automatic logic [RES_W-1:0] sig_step(input logic [RES_W-1:0] sig,
                                                input logic [RES_W-1:0] res);
    return {sig[RES_W-2:0], sig[RES_W-1]} ^ res;
  endfunction

endpackage

// File: rtl/c0880_vec_sequencer_if.sv
// c0880_vec_sequencer_if
// Byte-stream input and result-stream output of the vector sequencer.
//   s_byte/s_valid/s_ready  input byte stream, LSB-first vector fill
//   m_res/m_valid/m_ready   captured ALU result stream
// master: the sequencer side; slave: the environment feeding/draining it.
interface c0880_vec_sequencer_if;
  import c0880_pkg::*;

  logic [7:0]       s_byte;
  logic             s_valid;
  logic             s_ready;
  logic [RES_W-1:0] m_res;
  logic             m_valid;
  logic             m_ready;

  modport master (
    input  s_byte, s_valid, m_ready,
    output s_ready, m_res, m_valid
  );

  modport slave (
    output s_byte, s_valid, m_ready,
    input  s_ready, m_res, m_valid
  );

endinterface

// File: rtl/c0880_sig_reg.sv
// c0880_sig_reg
// Running 26-bit rotate-XOR signature of captured ALU results.
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset, clears the signature
//   en     fold res into the signature this edge
//   res    result word to fold in
//   sig    current signature
module c0880_sig_reg
  import c0880_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [RES_W-1:0] res,
  output logic [RES_W-1:0] sig
);

  logic [RES_W-1:0] sig_q;
  logic [RES_W-1:0] sig_d;

  // Signature only moves on a capture; otherwise it holds.
  always_comb begin
    sig_d = sig_q;
    if (en) begin
      sig_d = sig_step(sig_q, res);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/c0880_vec_sequencer.sv
// c0880_vec_sequencer
// Driver/capture stage wrapped around the combinational c0880 ALU netlist.
// Assembles a 60-bit vector from 8 streamed bytes, launches it onto alu_in
// in one step, waits SETTLE_CYCLES (legal 1..15), captures alu_out and
// offers it on a valid/ready output while folding it into a signature.
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        byte-in / result-out handshakes (master modport)
//   alu_in     to ALU, bit 0 = G1 .. bit 59 = G60
//   alu_out    from ALU, bit 0 = G855 .. bit 25 = G880
//   signature  running result signature
//   vec_count  completed captures, saturating at 0xFFFF
//   busy       high unless idle in LOAD at byte index 0
module c0880_vec_sequencer
  import c0880_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  c0880_vec_sequencer_if.master bus,
  output logic [VEC_W-1:0]     alu_in,
  input  logic [RES_W-1:0]     alu_out,
  output logic [RES_W-1:0]     signature,
  output logic [15:0]          vec_count,
  output logic                 busy
);

  localparam logic [1:0] LOAD_S   = ST_LOAD;
  localparam logic [1:0] SETTLE_S = ST_SETTLE;
  localparam logic [1:0] OUT_S    = ST_OUT;

  localparam logic [2:0] LAST_IDX    = 3'(BYTES_PER_VEC - 1);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [VEC_W-1:0] shadow_q, shadow_d;
  logic [VEC_W-1:0] alu_in_q, alu_in_d;
  logic [3:0]       settle_q, settle_d;
  logic [RES_W-1:0] m_res_q, m_res_d;
  logic             m_valid_q, m_valid_d;
  logic [15:0]      vec_count_q, vec_count_d;
  logic             capture;

  // Next-state logic. Bytes land in a shadow register so alu_in only ever
  // changes as a whole word at launch; the last byte carries just 4 bits.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    alu_in_d    = alu_in_q;
    settle_d    = settle_q;
    m_res_d     = m_res_q;
    m_valid_d   = m_valid_q;
    vec_count_d = vec_count_q;
    capture     = 1'b0;

    case (state_q)
      LOAD_S: begin
        if (bus.s_valid) begin
          if (idx_q == LAST_IDX) begin
            shadow_d = {bus.s_byte[3:0], shadow_q[55:0]};
            alu_in_d = {bus.s_byte[3:0], shadow_q[55:0]};
            idx_d    = 3'd0;
            settle_d = SETTLE_INIT;
            state_d  = SETTLE_S;
          end else begin
            shadow_d[{idx_q, 3'b000} +: 8] = bus.s_byte;
            idx_d = idx_q + 3'd1;
          end
        end
      end

      SETTLE_S: begin
        if (settle_q == 4'd1) begin
          m_res_d   = alu_out;
          m_valid_d = 1'b1;
          capture   = 1'b1;
          if (vec_count_q != 16'hFFFF) begin
            vec_count_d = vec_count_q + 16'd1;
          end
          state_d = OUT_S;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      OUT_S: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = LOAD_S;
        end
      end

      default: begin
        state_d = LOAD_S;
        idx_d   = 3'd0;
      end
    endcase
  end

  // State registers; reset discards any partial vector and pending result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD_S;
      idx_q       <= 3'd0;
      shadow_q    <= '0;
      alu_in_q    <= '0;
      settle_q    <= 4'd0;
      m_res_q     <= '0;
      m_valid_q   <= 1'b0;
      vec_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      alu_in_q    <= alu_in_d;
      settle_q    <= settle_d;
      m_res_q     <= m_res_d;
      m_valid_q   <= m_valid_d;
      vec_count_q <= vec_count_d;
    end
  end

  c0880_sig_reg u_sig_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (capture),
    .res   (alu_out),
    .sig   (signature)
  );

  assign bus.s_ready = (state_q == LOAD_S);
  assign bus.m_res   = m_res_q;
  assign bus.m_valid = m_valid_q;
  assign alu_in      = alu_in_q;
  assign vec_count   = vec_count_q;
  assign busy        = !((state_q == LOAD_S) && (idx_q == 3'd0));

endmodule

// File: tb/tb_c0880_vec_sequencer.sv
// tb_c0880_vec_sequencer
// Directed and randomized bench for c0880_vec_sequencer. dut1 runs with
// SETTLE_CYCLES=1 for the directed scenarios, dut3 with SETTLE_CYCLES=3 for
// the long randomized run. Both see a bench-side stand-in for the ALU.
module tb_c0880_vec_sequencer;
  import c0880_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  c0880_vec_sequencer_if bus1();
  c0880_vec_sequencer_if bus3();

  logic [VEC_W-1:0] alu_in1, alu_in3;
  logic [RES_W-1:0] alu_out1, alu_out3;
  logic [RES_W-1:0] sig1, sig3;
  logic [15:0]      cnt1, cnt3;
  logic             busy1, busy3;

  int checks = 0;
  int errors = 0;

  // Linear stand-in for the c0880 netlist; its G855/G858/G859/G861 values
  // for all-zero and all-ones inputs agree with the real netlist.
  function automatic logic [RES_W-1:0] alu_model(input logic [VEC_W-1:0] v);
    return v[25:0] ^ v[51:26] ^ {18'd0, v[59:52]} ^ 26'h0000019;
  endfunction

  assign alu_out1 = alu_model(alu_in1);
  assign alu_out3 = alu_model(alu_in3);

  c0880_vec_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1),
    .alu_in    (alu_in1),
    .alu_out   (alu_out1),
    .signature (sig1),
    .vec_count (cnt1),
    .busy      (busy1)
  );

  c0880_vec_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus3),
    .alu_in    (alu_in3),
    .alu_out   (alu_out3),
    .signature (sig3),
    .vec_count (cnt3),
    .busy      (busy3)
  );

  // Offer one byte and hold it until the DUT takes it (bounded).
  task automatic send_byte(input int which, input logic [7:0] b);
    int n;
    logic rdy;
    n = 0;
    if (which == 1) begin bus1.s_byte = b; bus1.s_valid = 1'b1; end
    else            begin bus3.s_byte = b; bus3.s_valid = 1'b1; end
    rdy = (which == 1) ? bus1.s_ready : bus3.s_ready;
    while (rdy !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      rdy = (which == 1) ? bus1.s_ready : bus3.s_ready;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("[TB] FAIL s_ready_timeout dut%0d s_ready=%b required 1", which, rdy);
    end
    @(posedge clk); #1;
    if (which == 1) bus1.s_valid = 1'b0;
    else            bus3.s_valid = 1'b0;
  endtask

  // Stream eight bytes, byte 0 first, with optional random idle gaps.
  task automatic send_vector(input int which, input logic [63:0] bytes, input int max_gap);
    int gap;
    for (int k = 0; k < 8; k++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      send_byte(which, bytes[8*k +: 8]);
    end
  endtask

  // Outputs of dut1 right after a reset edge.
  task automatic check_cleared(input string tag);
    checks++;
    if (alu_in1 !== '0 || bus1.m_res !== '0 || bus1.m_valid !== 1'b0 ||
        sig1 !== '0 || cnt1 !== 16'd0 || bus1.s_ready !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s alu_in=%h m_res=%h m_valid=%b sig=%h cnt=%h s_ready=%b busy=%b required all zero with s_ready=1",
               tag, alu_in1, bus1.m_res, bus1.m_valid, sig1, cnt1, bus1.s_ready, busy1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset_state");
    checks++;
    if (cnt3 !== 16'd0 || bus3.m_valid !== 1'b0 || sig3 !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state_dut3 cnt=%h m_valid=%b sig=%h required 0", cnt3, bus3.m_valid, sig3);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_all_zero();
    send_vector(1, 64'h0, 0);
    checks++;
    if (bus1.m_valid !== 1'b0 || bus1.s_ready !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_settle m_valid=%b s_ready=%b busy=%b required 0 0 1", bus1.m_valid, bus1.s_ready, busy1);
    end
    @(posedge clk); #1;
    checks++;
    if (bus1.m_valid !== 1'b1 || bus1.m_res !== 26'h0000019) begin
      errors++;
      $display("[TB] FAIL zero_result m_valid=%b m_res=%h required 1 0000019", bus1.m_valid, bus1.m_res);
    end
    checks++;
    if (cnt1 !== 16'd1 || sig1 !== 26'h0000019) begin
      errors++;
      $display("[TB] FAIL zero_sig cnt=%h sig=%h required 0001 0000019", cnt1, sig1);
    end
    @(posedge clk); #1;
    checks++;
    if (bus1.m_valid !== 1'b0 || bus1.s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_handoff m_valid=%b s_ready=%b required 0 1", bus1.m_valid, bus1.s_ready);
    end
  endtask

  task automatic test_all_ones();
    send_vector(1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    checks++;
    if (alu_in1 !== 60'hFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL ones_alu_in got %h required fffffffffffffff", alu_in1);
    end
    @(posedge clk); #1;
    checks++;
    if (bus1.m_valid !== 1'b1 || bus1.m_res !== 26'h00000E6) begin
      errors++;
      $display("[TB] FAIL ones_result m_valid=%b m_res=%h required 1 00000e6", bus1.m_valid, bus1.m_res);
    end
    checks++;
    if (cnt1 !== 16'd2 || sig1 !== 26'h00000D4) begin
      errors++;
      $display("[TB] FAIL ones_sig cnt=%h sig=%h required 0002 00000d4", cnt1, sig1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_order();
    send_vector(1, 64'hF800_0000_0000_0001, 0);
    checks++;
    if (alu_in1 !== 60'h800_0000_0000_0001) begin
      errors++;
      $display("[TB] FAIL byte_order_alu_in got %h required 800000000000001", alu_in1);
    end
    @(posedge clk); #1;
    checks++;
    if (bus1.m_res !== 26'h0000098 || sig1 !== 26'h0000130 || cnt1 !== 16'd3) begin
      errors++;
      $display("[TB] FAIL byte_order_result m_res=%h sig=%h cnt=%h required 0000098 0000130 0003",
               bus1.m_res, sig1, cnt1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [RES_W-1:0] exp_res;
    int n;
    bus1.m_ready = 1'b0;
    exp_res = alu_model(60'h877_6655_4433_2211);
    send_vector(1, 64'h8877_6655_4433_2211, 0);
    n = 0;
    while (bus1.m_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 1) begin
      errors++;
      $display("[TB] FAIL bp_latency cycles=%0d required 1", n);
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (bus1.m_valid !== 1'b1 || bus1.m_res !== exp_res || bus1.s_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d m_valid=%b m_res=%h s_ready=%b required 1 %h 0",
                 c, bus1.m_valid, bus1.m_res, bus1.s_ready, exp_res);
      end
      @(posedge clk); #1;
    end
    bus1.m_ready = 1'b1;
    @(posedge clk); #1;
    bus1.m_ready = 1'b0;
    checks++;
    if (bus1.m_valid !== 1'b0 || bus1.s_ready !== 1'b1 || cnt1 !== 16'd4) begin
      errors++;
      $display("[TB] FAIL bp_release m_valid=%b s_ready=%b cnt=%h required 0 1 0004", bus1.m_valid, bus1.s_ready, cnt1);
    end
    bus1.s_byte  = 8'h5A;
    bus1.s_valid = 1'b1;
    @(posedge clk); #1;
    bus1.s_valid = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_next_byte busy=%b required 1", busy1);
    end
    bus1.m_ready = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    send_byte(1, 8'hAA);
    send_byte(1, 8'hBB);
    send_byte(1, 8'hCC);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_cleared("reset_mid_load");
    rst_n = 1'b1;
    send_vector(1, 64'h0123_4567_89AB_CDEF, 0);
    checks++;
    if (alu_in1 !== 60'h123_4567_89AB_CDEF) begin
      errors++;
      $display("[TB] FAIL fresh_after_load_alu_in got %h required 123456789abcdef", alu_in1);
    end
    @(posedge clk); #1;
    checks++;
    if (bus1.m_res !== alu_model(60'h123_4567_89AB_CDEF) || cnt1 !== 16'd1 ||
        sig1 !== alu_model(60'h123_4567_89AB_CDEF)) begin
      errors++;
      $display("[TB] FAIL fresh_after_load_result m_res=%h sig=%h cnt=%h required %h %h 0001",
               bus1.m_res, sig1, cnt1, alu_model(60'h123_4567_89AB_CDEF), alu_model(60'h123_4567_89AB_CDEF));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_settle();
    send_vector(1, 64'h5555_5555_5555_5555, 0);
    checks++;
    if (busy1 !== 1'b1 || bus1.s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL settle_entry busy=%b s_ready=%b required 1 0", busy1, bus1.s_ready);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_cleared("reset_mid_settle");
    rst_n = 1'b1;
    send_vector(1, 64'h0F0F_0F0F_F0F0_F0F0, 0);
    @(posedge clk); #1;
    checks++;
    if (bus1.m_valid !== 1'b1 || bus1.m_res !== alu_model(60'hF0F_0F0F_F0F0_F0F0) || cnt1 !== 16'd1) begin
      errors++;
      $display("[TB] FAIL fresh_after_settle m_valid=%b m_res=%h cnt=%h required 1 %h 0001",
               bus1.m_valid, bus1.m_res, cnt1, alu_model(60'hF0F_0F0F_F0F0_F0F0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [63:0]      bytes;
    logic [RES_W-1:0] exp_res;
    logic [RES_W-1:0] sig_model;
    int               n;
    int               hold;
    sig_model    = '0;
    bus3.m_ready = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      bytes   = {$urandom, $urandom};
      exp_res = alu_model(bytes[59:0]);
      send_vector(3, bytes, 2);
      n = 0;
      while (bus3.m_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      checks++;
      if (n != 3) begin
        errors++;
        $display("[TB] FAIL rand_latency vec %0d cycles=%0d required 3", i, n);
      end
      checks++;
      if (bus3.m_res !== exp_res) begin
        errors++;
        $display("[TB] FAIL rand_result vec %0d m_res=%h required %h", i, bus3.m_res, exp_res);
      end
      sig_model = {sig_model[24:0], sig_model[25]} ^ exp_res;
      hold = int'($urandom_range(2, 0));
      repeat (hold) begin @(posedge clk); #1; end
      bus3.m_ready = 1'b1;
      @(posedge clk); #1;
      bus3.m_ready = 1'b0;
    end
    checks++;
    if (cnt3 !== 16'd1000) begin
      errors++;
      $display("[TB] FAIL rand_count got %0d required 1000", cnt3);
    end
    checks++;
    if (sig3 !== sig_model) begin
      errors++;
      $display("[TB] FAIL rand_signature got %h required %h", sig3, sig_model);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus1.s_byte  = 8'h00;
    bus1.s_valid = 1'b0;
    bus1.m_ready = 1'b1;
    bus3.s_byte  = 8'h00;
    bus3.s_valid = 1'b0;
    bus3.m_ready = 1'b0;

    test_reset();
    test_all_zero();
    test_all_ones();
    test_byte_order();
    test_backpressure();
    test_reset_mid_load();
    test_reset_mid_settle();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c0880_vec_sequencer.md
Name: c0880_vec_sequencer

Overview:
- Sequential driver stage placed directly upstream of the combinational c0880 ALU netlist; also captures its results.
- Assembles a 60-bit input vector (G1..G60) from an 8-bit byte stream and holds it stable on the ALU inputs.
- Waits a programmable settle time, then samples the 26-bit ALU result (G855..G880).
- Presents the result on a valid/ready output and folds it into a running signature for self-checking.

Parameters:
- SETTLE_CYCLES, 1, cycles between vector launch and result capture; legal range 1..15.
- VEC_W, 60, ALU input width; fixed.
- RES_W, 26, ALU output width; fixed.

Ports:
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- s_byte  in  8  input byte; LSB-first vector fill.
- s_valid  in  1  s_byte valid.
- s_ready  out  1  byte accepted when s_valid and s_ready are both high at a clock edge.
- alu_in  out  60  to ALU; bit 0 = G1 ... bit 59 = G60.
- alu_out  in  26  from ALU; bit 0 = G855 ... bit 25 = G880.
- m_res  out  26  captured result.
- m_valid  out  1  m_res valid.
- m_ready  in  1  downstream accepts.
- signature  out  26  running result signature.
- vec_count  out  16  completed captures; saturates at 0xFFFF.
- busy  out  1  high in any state other than LOAD with byte index 0.

Behaviour:
- Reset (rst_n low at an edge) forces:
  - state LOAD, byte index 0, shadow register 0.
  - alu_in 0, m_res 0, m_valid 0, signature 0, vec_count 0.
- Reset mid-operation discards any partial vector and any pending result.
- State machine:
  - LOAD:
    - s_ready=1.
    - Byte k (k=0..7) is written to shadow[8k+7:8k].
    - For k=7, only s_byte[3:0] goes to shadow[59:56]; s_byte[7:4] is ignored.
    - Bytes 0..6 increment the index.
    - On accepting byte 7, in the same edge: alu_in <= completed shadow (with byte 7 merged), index <= 0, settle_cnt <= SETTLE_CYCLES, state -> SETTLE.
  - SETTLE:
    - s_ready=0.
    - alu_in is held stable.
    - Each edge: if settle_cnt==1, then m_res <= alu_out, m_valid <= 1, signature and vec_count update, state -> OUT. Otherwise settle_cnt decrements.
  - OUT:
    - s_ready=0.
    - m_valid=1 and m_res are held until m_ready is high at an edge; then m_valid <= 0 and state -> LOAD.
    - No byte is accepted in the handoff cycle.
- Signature update: signature <= {signature[24:0], signature[25]} XOR alu_out. It updates only at capture.
- alu_in changes only on launch; it is never partially updated while the ALU is being sampled.
- Latency: last byte accepted at edge T gives m_valid high after edge T+SETTLE_CYCLES.
- Throughput: one vector per 8 + SETTLE_CYCLES + 1 cycles at best (m_ready tied high).
- s_valid low in LOAD stalls without state change. m_ready low in OUT stalls indefinitely.
- vec_count wraps never; it holds at 0xFFFF.

Decomposition:
- Shared package c0880_pkg holds:
  - VEC_W=60, RES_W=26, BYTES_PER_VEC=8.
  - State enum {LOAD, SETTLE, OUT}.
  - Signature-step function.
- One natural sub-module: c0880_sig_reg, the 26-bit rotate-XOR signature register with enable and sync active-low reset.
- The ALU netlist is instantiated by the bench/top, not inside this block.

Test Plan:
- All-zero vector: 8 bytes 0x00, SETTLE_CYCLES=1, m_ready=1.
  - m_valid rises 1 cycle after the last byte.
  - m_res[0] (G855)=1, m_res[3] (G858)=1, m_res[6] (G861)=0.
  - vec_count=1; signature equals m_res.
- All-ones vector: bytes 0xFF x8.
  - alu_in = 60'hFFF_FFFF_FFFF_FFFF.
  - m_res[0]=0, m_res[3]=0, m_res[4] (G859)=0.
  - Signature = rotl(prev sig) XOR m_res.
- Byte order: bytes 0x01,0x00 x6,0xF8.
  - alu_in bit 0 (G1)=1, bits 59:56=4'h8, all other bits 0; upper nibble ignored.
- Backpressure: hold m_ready=0 for 20 cycles.
  - m_res and m_valid stay stable and s_ready=0 throughout.
  - After m_ready pulses, the next byte is accepted one cycle later.
- Reset mid-load and mid-SETTLE: assert rst_n=0 after 3 bytes, and separately during SETTLE.
  - All outputs are 0 next cycle.
  - The next 8 bytes form a fresh vector.
- Random 1000 vectors against the ALU golden model with random s_valid/m_ready gaps, SETTLE_CYCLES=3.
  - Every m_res matches the model.
  - vec_count=1000; signature matches the model fold.
